// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequences one VEC_LEN dot product on a shared MAC (clk/rst, start/busy, A/B FIFO pop, mac_en/clr/a/b/cout, result valid/ready)
module mac_seq_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int VEC_LEN    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    input  logic                    a_empty,
    input  logic                    b_empty,
    output logic                    a_rden,
    output logic                    b_rden,
    input  logic [DATA_WIDTH-1:0]   a_data,
    input  logic [DATA_WIDTH-1:0]   b_data,
    output logic                    mac_en,
    output logic                    mac_clr,
    output logic [DATA_WIDTH-1:0]   mac_a,
    output logic [DATA_WIDTH-1:0]   mac_b,
    input  logic [3*DATA_WIDTH-1:0] mac_cout,
    output logic [3*DATA_WIDTH-1:0] result,
    output logic                    result_valid,
    input  logic                    result_ready
);
    localparam int CW = $clog2(VEC_LEN + 1);
    localparam logic [CW-1:0] LEN = CW'(VEC_LEN);
    typedef enum logic [2:0] {IDLE, CLEAR, RUN, WAIT, RESULT} state_t;
    state_t state, state_n;
    logic [CW-1:0] issue_cnt;
    logic pend;
    logic pop;
    always_comb begin
        state_n = state;
        pop = 1'b0;
        case (state)
            IDLE:    state_n = start ? CLEAR : IDLE;
            CLEAR:   state_n = RUN;
            RUN: begin
                pop = !a_empty && !b_empty && issue_cnt < LEN;
                state_n = (issue_cnt == LEN && pend) ? WAIT : RUN;
            end
            WAIT:    state_n = RESULT;
            RESULT:  state_n = result_ready ? IDLE : RESULT;
            default: state_n = IDLE;
        endcase
    end
    assign a_rden       = pop;
    assign b_rden       = pop;
    assign mac_en       = state == RUN && pend;
    assign mac_clr      = state == CLEAR;
    assign mac_a        = pend ? a_data : '0;
    assign mac_b        = pend ? b_data : '0;
    assign busy         = state != IDLE;
    assign result_valid = state == RESULT;
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            issue_cnt <= '0;
            pend      <= 1'b0;
            result    <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE) begin
                issue_cnt <= '0;
                pend      <= 1'b0;
            end
            if (state == RUN) begin
                issue_cnt <= issue_cnt + CW'(pop);
                pend      <= pop;
            end
            if (state == WAIT)
                result <= mac_cout;
        end
    end
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: randomized self-checking bench with FIFO/MAC models and a dot-product/latency reference
module tb_mac_seq_ctrl;
    logic clk = 1'b0;
    logic rst, start, result_ready;
    logic busy, a_empty, b_empty, a_rden, b_rden, mac_en, mac_clr, result_valid;
    logic [7:0] a_data = '0, b_data = '0, mac_a, mac_b;
    logic [23:0] acc = '0, result;
    logic [9:0] a_rd = '0, a_wr = '0, b_rd = '0, b_wr = '0;
    logic [7:0] a_mem [1024];
    logic [7:0] b_mem [1024];
    logic a_stall, b_stall, rnd_start;
    int rd_cnt = 0, en_cnt = 0, viol = 0, hs_cnt = 0;
    logic start1, busy1, a1_empty, b1_empty, a1_rden, b1_rden, mac_en1, mac_clr1, result_valid1;
    logic [7:0] a1_data = '0, b1_data = '0, mac_a1, mac_b1, a1_val, b1_val;
    logic [23:0] acc1 = '0, result1;
    logic [9:0] a1_rd = '0, a1_wr = '0, b1_rd = '0, b1_wr = '0;
    int rd1_cnt = 0;
    logic [7:0] ma [8];
    logic [7:0] mb [8];
    logic sa [64];
    logic sb [64];
    logic [23:0] exp_res;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    assign a_empty  = (a_rd == a_wr) || a_stall;
    assign b_empty  = (b_rd == b_wr) || b_stall;
    assign a1_empty = a1_rd == a1_wr;
    assign b1_empty = b1_rd == b1_wr;

    mac_seq_ctrl #(.DATA_WIDTH(8), .VEC_LEN(8)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .a_empty(a_empty), .b_empty(b_empty), .a_rden(a_rden), .b_rden(b_rden),
        .a_data(a_data), .b_data(b_data), .mac_en(mac_en), .mac_clr(mac_clr),
        .mac_a(mac_a), .mac_b(mac_b), .mac_cout(acc), .result(result),
        .result_valid(result_valid), .result_ready(result_ready)
    );

    mac_seq_ctrl #(.DATA_WIDTH(8), .VEC_LEN(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1),
        .a_empty(a1_empty), .b_empty(b1_empty), .a_rden(a1_rden), .b_rden(b1_rden),
        .a_data(a1_data), .b_data(b1_data), .mac_en(mac_en1), .mac_clr(mac_clr1),
        .mac_a(mac_a1), .mac_b(mac_b1), .mac_cout(acc1), .result(result1),
        .result_valid(result_valid1), .result_ready(result_ready)
    );

    always @(posedge clk) begin
        if (a_rden) begin
            a_data <= a_mem[a_rd];
            a_rd   <= a_rd + 10'd1;
        end
        if (b_rden) begin
            b_data <= b_mem[b_rd];
            b_rd   <= b_rd + 10'd1;
        end
        if (mac_clr) acc <= '0;
        else if (mac_en) acc <= acc + 24'(mac_a) * 24'(mac_b);
        rd_cnt <= rd_cnt + int'(a_rden);
        en_cnt <= en_cnt + int'(mac_en);
        hs_cnt <= hs_cnt + int'(result_valid && result_ready);
        if (a_rden !== b_rden || (a_rden && (a_empty || b_empty))) viol <= viol + 1;
        if (a1_rden) begin
            a1_data <= a1_val;
            a1_rd   <= a1_rd + 10'd1;
        end
        if (b1_rden) begin
            b1_data <= b1_val;
            b1_rd   <= b1_rd + 10'd1;
        end
        if (mac_clr1) acc1 <= '0;
        else if (mac_en1) acc1 <= acc1 + 24'(mac_a1) * 24'(mac_b1);
        rd1_cnt <= rd1_cnt + int'(a1_rden);
    end

    task automatic load();
        exp_res = '0;
        for (int i = 0; i < 8; i++) begin
            a_mem[a_wr] = ma[i];
            b_mem[b_wr] = mb[i];
            a_wr = a_wr + 10'd1;
            b_wr = b_wr + 10'd1;
            exp_res = exp_res + 24'(ma[i]) * 24'(mb[i]);
        end
    endtask

    task automatic no_stalls();
        for (int k = 0; k < 64; k++) begin
            sa[k] = 1'b0;
            sb[k] = 1'b0;
        end
    endtask

    // first-valid cycle: pops happen from cycle 2 in every unstalled cycle; valid 3 cycles after the last pop
    function automatic int exp_lat();
        int c = 2;
        int p = 0;
        while (p < 8) begin
            if (c >= 64 || !(sa[c] || sb[c])) p++;
            c++;
        end
        return c + 2;
    endfunction

    // called at a negedge (cycle 0); returns at the negedge of the first valid cycle
    task automatic go(output int lat, output logic [23:0] res);
        lat = -1;
        res = '0;
        start = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            a_stall = k < 64 ? sa[k] : 1'b0;
            b_stall = k < 64 ? sb[k] : 1'b0;
            start = rnd_start && busy && !result_valid && $urandom_range(0, 2) == 0;
            if (result_valid) begin
                lat = k;
                res = result;
                break;
            end
        end
        start = 1'b0;
        a_stall = 1'b0;
        b_stall = 1'b0;
    endtask

    task automatic pattern_data();
        for (int i = 0; i < 8; i++) begin
            ma[i] = 8'(5 * (i + 1));
            mb[i] = 8'(10 * (i + 1));
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++;
        if ({busy, a_rden, b_rden, mac_en, mac_clr, mac_a, mac_b, result, result_valid} !== 46'd0) begin
            fails++;
            $display("FAIL reset_outputs: busy=%b rden=%b%b en=%b clr=%b a=%0d b=%0d result=%0d valid=%b, all 0 required",
                     busy, a_rden, b_rden, mac_en, mac_clr, mac_a, mac_b, result, result_valid);
        end
        tests++;
        if ({busy1, result_valid1, result1} !== 26'd0) begin
            fails++;
            $display("FAIL reset_outputs_vec1: busy=%b valid=%b result=%0d, all 0 required", busy1, result_valid1, result1);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_pattern();
        int lat, r0, e0;
        logic [23:0] res;
        pattern_data();
        load();
        no_stalls();
        r0 = rd_cnt;
        e0 = en_cnt;
        go(lat, res);
        tests++;
        if (res !== exp_res) begin fails++; $display("FAIL pattern_result: got %0d expected %0d", res, exp_res); end
        tests++;
        if (lat != 12) begin fails++; $display("FAIL pattern_latency: got %0d expected 12", lat); end
        @(negedge clk);
        tests++;
        if (result_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL pattern_single_valid: valid=%b busy=%b expected 0 0", result_valid, busy);
        end
        tests++;
        if (rd_cnt - r0 != 8) begin fails++; $display("FAIL pattern_rden_pulses: got %0d expected 8", rd_cnt - r0); end
        tests++;
        if (en_cnt - e0 != 8) begin fails++; $display("FAIL pattern_en_pulses: got %0d expected 8", en_cnt - e0); end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [23:0] res;
        for (int i = 0; i < 8; i++) begin
            ma[i] = 8'd255;
            mb[i] = 8'd255;
        end
        load();
        no_stalls();
        go(lat, res);
        tests++;
        if (res !== exp_res) begin fails++; $display("FAIL max_result: got %0d expected %0d", res, exp_res); end
        tests++;
        if (lat != 12) begin fails++; $display("FAIL max_latency: got %0d expected 12", lat); end
        for (int i = 0; i < 8; i++) begin
            ma[i] = 8'd1;
            mb[i] = 8'd1;
        end
        load();
        @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL b2b_idle_busy: got %b expected 0", busy); end
        go(lat, res);
        tests++;
        if (res !== exp_res) begin fails++; $display("FAIL b2b_clear_result: got %0d expected %0d", res, exp_res); end
        tests++;
        if (lat != 12) begin fails++; $display("FAIL b2b_latency: got %0d expected 12", lat); end
        @(negedge clk);
    endtask

    task automatic test_stall();
        int lat, r0, v0, el;
        logic [23:0] res;
        pattern_data();
        load();
        no_stalls();
        sb[6] = 1'b1;
        sb[7] = 1'b1;
        sb[8] = 1'b1;
        el = exp_lat();
        r0 = rd_cnt;
        v0 = viol;
        go(lat, res);
        tests++;
        if (res !== exp_res) begin fails++; $display("FAIL stall_result: got %0d expected %0d", res, exp_res); end
        tests++;
        if (lat != el) begin fails++; $display("FAIL stall_latency: got %0d expected %0d", lat, el); end
        @(negedge clk);
        tests++;
        if (viol != v0) begin fails++; $display("FAIL stall_pop_rules: %0d illegal pops, expected 0", viol - v0); end
        tests++;
        if (rd_cnt - r0 != 8) begin fails++; $display("FAIL stall_rden_pulses: got %0d expected 8", rd_cnt - r0); end
    endtask

    task automatic test_backpressure();
        int lat, r0, h0;
        logic [23:0] res;
        for (int i = 0; i < 8; i++) begin
            ma[i] = 8'($urandom_range(0, 255));
            mb[i] = 8'($urandom_range(0, 255));
        end
        load();
        no_stalls();
        r0 = rd_cnt;
        h0 = hs_cnt;
        result_ready = 1'b0;
        go(lat, res);
        tests++;
        if (res !== exp_res) begin fails++; $display("FAIL bp_result: got %0d expected %0d", res, exp_res); end
        for (int i = 0; i < 5; i++) begin
            start = i == 2;
            @(negedge clk);
            tests++;
            if (result_valid !== 1'b1 || result !== exp_res) begin
                fails++;
                $display("FAIL bp_hold_%0d: valid=%b result=%0d expected 1 %0d", i, result_valid, result, exp_res);
            end
        end
        start = 1'b0;
        result_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (result_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL bp_release: valid=%b busy=%b expected 0 0", result_valid, busy);
        end
        repeat (2) @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL bp_start_ignored: busy=%b expected 0", busy); end
        tests++;
        if (hs_cnt - h0 != 1 || rd_cnt - r0 != 8) begin
            fails++;
            $display("FAIL bp_one_completion: handshakes=%0d pops=%0d expected 1 8", hs_cnt - h0, rd_cnt - r0);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        logic [23:0] res;
        logic [9:0] a0;
        pattern_data();
        a0 = a_rd;
        load();
        no_stalls();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 20 && a_rd != a0 + 10'd3; k++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if ({busy, a_rden, b_rden, mac_en, mac_clr, mac_a, mac_b, result, result_valid} !== 46'd0) begin
            fails++;
            $display("FAIL midrun_reset: busy=%b rden=%b%b en=%b clr=%b a=%0d b=%0d result=%0d valid=%b, all 0 required",
                     busy, a_rden, b_rden, mac_en, mac_clr, mac_a, mac_b, result, result_valid);
        end
        rst = 1'b0;
        a_wr = a_rd;
        b_wr = b_rd;
        for (int i = 0; i < 8; i++) begin
            ma[i] = 8'($urandom_range(1, 255));
            mb[i] = 8'($urandom_range(1, 255));
        end
        load();
        @(negedge clk);
        go(lat, res);
        tests++;
        if (res !== exp_res) begin fails++; $display("FAIL midrun_fresh_result: got %0d expected %0d", res, exp_res); end
        tests++;
        if (lat != 12) begin fails++; $display("FAIL midrun_fresh_latency: got %0d expected 12", lat); end
        @(negedge clk);
    endtask

    task automatic test_vec1();
        int lat, r0;
        lat = -1;
        r0 = rd1_cnt;
        a1_val = 8'd7;
        b1_val = 8'd8;
        a1_wr = a1_wr + 10'd1;
        b1_wr = b1_wr + 10'd1;
        start1 = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            start1 = k <= 3;
            if (result_valid1) begin
                lat = k;
                break;
            end
        end
        start1 = 1'b0;
        tests++;
        if (result1 !== 24'(a1_val) * 24'(b1_val)) begin
            fails++;
            $display("FAIL vec1_result: got %0d expected %0d", result1, 24'(a1_val) * 24'(b1_val));
        end
        tests++;
        if (lat != 5) begin fails++; $display("FAIL vec1_latency: got %0d expected 5", lat); end
        @(negedge clk);
        tests++;
        if (result_valid1 !== 1'b0 || busy1 !== 1'b0) begin
            fails++;
            $display("FAIL vec1_done: valid=%b busy=%b expected 0 0", result_valid1, busy1);
        end
        tests++;
        if (rd1_cnt - r0 != 1) begin fails++; $display("FAIL vec1_pops: got %0d expected 1", rd1_cnt - r0); end
    endtask

    task automatic test_random();
        int lat, r0, v0, el;
        logic [23:0] res;
        rnd_start = 1'b1;
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < 8; i++) begin
                ma[i] = 8'($urandom_range(0, 255));
                mb[i] = 8'($urandom_range(0, 255));
            end
            load();
            no_stalls();
            for (int k = 2; k < 40; k++) begin
                sa[k] = $urandom_range(0, 3) == 0;
                sb[k] = $urandom_range(0, 3) == 0;
            end
            el = exp_lat();
            r0 = rd_cnt;
            v0 = viol;
            go(lat, res);
            tests++;
            if (res !== exp_res) begin fails++; $display("FAIL rand%0d_result: got %0d expected %0d", n, res, exp_res); end
            tests++;
            if (lat != el) begin fails++; $display("FAIL rand%0d_latency: got %0d expected %0d", n, lat, el); end
            @(negedge clk);
            tests++;
            if (rd_cnt - r0 != 8 || viol != v0) begin
                fails++;
                $display("FAIL rand%0d_pops: pops=%0d illegal=%0d expected 8 0", n, rd_cnt - r0, viol - v0);
            end
        end
        rnd_start = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        start1 = 1'b0;
        result_ready = 1'b1;
        a_stall = 1'b0;
        b_stall = 1'b0;
        rnd_start = 1'b0;
        a1_val = '0;
        b1_val = '0;
        test_reset();
        test_pattern();
        test_back_to_back();
        test_stall();
        test_backpressure();
        test_reset_mid_run();
        test_vec1();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
